adder_tree_pipe: RTL and testbench

- Parametrised, pipelined, signed multi-operand adder for the FFT datapath.
- Sums M operands of N bits through a registered binary tree.
- Applies a runtime arithmetic right-shift for block-scaling between FFT stages, then saturates or wraps the result to N bits and flags overflow.
- Carries a valid bit alongside the data and supports a pipeline-wide clock enable for stalling.

---
 rtl/adder_tree_pipe.sv | 142 ++++++++++++++
 tb/tb_adder_tree_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe
//   Pipelined signed multi-operand adder for the FFT datapath. M operands of
//   N bits are sign-extended to W = N + clog2(M) bits and summed through a
//   registered binary tree. The full-precision sum is arithmetically shifted
//   right by a per-beat block-scaling amount. It is then saturated (SAT=1) or
//   wrapped (SAT=0) to N bits, and an overflow flag is raised when the scaled
//   value does not fit. Latency is G+1 enabled cycles; i_ce stalls every
//   register.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_ce     clock enable; low holds every pipeline register
//   i_valid  input operands valid
//   i_data   packed operands, operand k at [k*N +: N], signed
//   i_shift  arithmetic right shift for this beat (clamped to G)
//   o_valid  o_sum / o_ovf valid
//   o_sum    scaled, saturated or wrapped sum, signed
//   o_ovf    scaled sum fell outside the N-bit signed range
module adder_tree_pipe #(
  parameter int N   = 16,
  parameter int M   = 3,
  parameter int SAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_ce,
  input  logic           i_valid,
  input  logic [M*N-1:0] i_data,
  input  logic [3:0]     i_shift,
  output logic           o_valid,
  output logic [N-1:0]   o_sum,
  output logic           o_ovf
);

  localparam int G = $clog2(M);
  localparam int W = N + G;

  // Signed N-bit limits expressed at full internal width.
  localparam logic signed [W-1:0] MAX_V = {{(G+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(G+1){1'b1}}, {(N-1){1'b0}}};

  // Number of partial sums held at tree level lvl (level 0 = the operands).
  function automatic int level_count(input int lvl);
    int c;
    c = M;
    for (int i = 0; i < lvl; i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  // Tree: level 0 is the sign-extended operands, levels 1..G are registered.
  for (genvar j = 0; j <= G; j++) begin : g_lvl
    localparam int CNT = level_count(j);
    for (genvar k = 0; k < CNT; k++) begin : g_n
      logic signed [W-1:0] node;
      if (j == 0) begin : g_ext
        assign node = {{G{i_data[k*N+N-1]}}, i_data[k*N +: N]};
      end else if (2*k+1 < level_count(j-1)) begin : g_add
        // Pairwise full-precision add of two nodes from the level below.
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            node <= {W{1'b0}};
          end else if (i_ce) begin
            node <= g_lvl[j-1].g_n[2*k].node + g_lvl[j-1].g_n[2*k+1].node;
          end
        end
      end else begin : g_pass
        // Odd leftover term: registered unchanged to keep levels aligned.
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            node <= {W{1'b0}};
          end else if (i_ce) begin
            node <= g_lvl[j-1].g_n[2*k].node;
          end
        end
      end
    end
  end

  logic [3:0]   sh_pipe [G];
  logic [G-1:0] v_pipe;

  // Shift amount and valid travel alongside the tree, one stage per level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < G; i++) begin
        sh_pipe[i] <= 4'd0;
      end
      v_pipe <= {G{1'b0}};
    end else if (i_ce) begin
      sh_pipe[0] <= i_shift;
      v_pipe[0]  <= i_valid;
      for (int i = 1; i < G; i++) begin
        sh_pipe[i] <= sh_pipe[i-1];
        v_pipe[i]  <= v_pipe[i-1];
      end
    end
  end

  logic signed [W-1:0] full_sum;
  logic signed [W-1:0] scaled;
  logic [3:0]          eff_shift;
  logic [N-1:0]        next_sum;
  logic                next_ovf;

  assign full_sum = g_lvl[G].g_n[0].node;

  // Scale, range-check and saturate/wrap the tree result.
  always_comb begin
    eff_shift = sh_pipe[G-1];
    if (sh_pipe[G-1] > 4'(G)) begin
      eff_shift = 4'(G);
    end else begin
      eff_shift = sh_pipe[G-1];
    end
    scaled   = full_sum >>> eff_shift;
    next_ovf = (scaled > MAX_V) || (scaled < MIN_V);
    if ((SAT != 0) && (scaled > MAX_V)) begin
      next_sum = MAX_V[N-1:0];
    end else if ((SAT != 0) && (scaled < MIN_V)) begin
      next_sum = MIN_V[N-1:0];
    end else begin
      next_sum = scaled[N-1:0];
    end
  end

  // Output register; invalid beats update data too, o_valid qualifies them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_sum   <= {N{1'b0}};
      o_ovf   <= 1'b0;
    end else if (i_ce) begin
      o_valid <= v_pipe[G-1];
      o_sum   <= next_sum;
      o_ovf   <= next_ovf;
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
module tb_adder_tree_pipe;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        valid;
  logic [3:0]  shift;
  logic [63:0] data4;
  logic [47:0] data3;

  logic        v4s, ov4s, v4w, ov4w, v3, ov3;
  logic [15:0] s4s, s4w, s3;

  int n_tests = 0;
  int n_fail  = 0;

  adder_tree_pipe #(.N(16), .M(4), .SAT(1)) u_dut4s (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data4),
    .i_shift(shift), .o_valid(v4s), .o_sum(s4s), .o_ovf(ov4s));

  adder_tree_pipe #(.N(16), .M(4), .SAT(0)) u_dut4w (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data4),
    .i_shift(shift), .o_valid(v4w), .o_sum(s4w), .o_ovf(ov4w));

  adder_tree_pipe #(.N(16), .M(3), .SAT(1)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data3),
    .i_shift(shift), .o_valid(v3), .o_sum(s3), .o_ovf(ov3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [47:0] pack3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  // Reference for M=4, SAT=1: {ovf, sum}.
  function automatic logic [16:0] ref4(input int a, input int b, input int c,
                                       input int d, input int sh);
    int s, t, es;
    s  = a + b + c + d;
    es = (sh > 2) ? 2 : sh;
    t  = s >>> es;
    if (t > 32767)       return {1'b1, 16'h7fff};
    else if (t < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, 16'(t)};
  endfunction

  // One isolated valid beat; checks latency and all three results.
  task automatic beat(input string tag, input int a, input int b, input int c, input int d,
                      input int p, input int q, input int r, input logic [3:0] sh,
                      input int e4s, input int o4s, input int e4w, input int o4w,
                      input int e3, input int o3);
    @(negedge clk);
    ce = 1'b1; valid = 1'b1; shift = sh;
    data4 = pack4(a, b, c, d); data3 = pack3(p, q, r);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check({tag, "_early_valid"}, {31'd0, v4s}, 0);
    @(negedge clk);
    check({tag, "_valid4s"}, {31'd0, v4s}, 1);
    check({tag, "_sum4s"},   $signed(s4s), e4s);
    check({tag, "_ovf4s"},   {31'd0, ov4s}, o4s);
    check({tag, "_valid4w"}, {31'd0, v4w}, 1);
    check({tag, "_sum4w"},   $signed(s4w), e4w);
    check({tag, "_ovf4w"},   {31'd0, ov4w}, o4w);
    check({tag, "_valid3"},  {31'd0, v3}, 1);
    check({tag, "_sum3"},    $signed(s3), e3);
    check({tag, "_ovf3"},    {31'd0, ov3}, o3);
  endtask

  int          sop [8][4];
  int          ssh [8];
  int          ce_pat [4] = '{1, 0, 0, 1};
  logic [16:0] exp_q [$];
  int          out_cnt;
  int          stale;

  initial begin
    rst = 1'b1; ce = 1'b1; valid = 1'b0; shift = 4'd0;
    data4 = 64'd0; data3 = 48'd0;
    #3;
    check("rst_valid", {31'd0, v4s}, 0);
    check("rst_sum",   $signed(s4s), 0);
    check("rst_ovf",   {31'd0, ov4s}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: (M=4 ops), (M=3 ops), shift, expectations.
    beat("basic", 1000, 2000, 3000, 4000, 1000, 2000, 3000, 4'd0,
         10000, 0, 10000, 0, 6000, 0);
    beat("pos_ovf", 20000, 20000, 20000, 20000, 32767, 32767, -32768, 4'd0,
         32767, 1, 14464, 1, 32766, 0);
    beat("neg_ovf", -20000, -20000, -20000, -20000, -32768, -32768, -32768, 4'd0,
         -32768, 1, -14464, 1, -32768, 1);
    beat("shift2", 20000, 20000, 20000, 20000, 32767, 32767, 32767, 4'd2,
         20000, 0, 20000, 0, 24575, 0);
    beat("floor", -7, 0, 0, 0, -7, 0, 0, 4'd2,
         -2, 0, -2, 0, -2, 0);
    beat("shift_clamp", 20000, 20000, 20000, 20000, 100, 0, 0, 4'd9,
         20000, 0, 20000, 0, 25, 0);
    beat("shift1", 3, 0, 0, 0, -3, 0, 0, 4'd1,
         1, 0, 1, 0, -2, 0);

    // Stream with clock-enable stalls and valid gaps (M=4 saturating DUT).
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        sop[k][j] = (k == 5) ? 20000 : (k * 3137 - 9000) + j * 500;
      end
      ssh[k] = (k == 5) ? 0 : k % 4;
    end
    out_cnt = 0;
    fork
      begin : drv
        int b, cyc;
        b = 0; cyc = 0;
        while (b < 8 && cyc < 80) begin
          @(negedge clk);
          ce    = ce_pat[cyc % 4][0];
          valid = (cyc % 5 != 2);
          data4 = pack4(sop[b][0], sop[b][1], sop[b][2], sop[b][3]);
          shift = 4'(ssh[b]);
          @(posedge clk);
          if (ce && valid) begin
            exp_q.push_back(ref4(sop[b][0], sop[b][1], sop[b][2], sop[b][3], ssh[b]));
            b++;
          end
          cyc++;
        end
        @(negedge clk);
        valid = 1'b0; ce = 1'b1;
        check("stream_accepted", b, 8);
      end
      begin : mon
        logic [15:0] last_sum;
        logic        last_v;
        logic        ce_prev;
        logic [16:0] e;
        last_sum = s4s; last_v = v4s;
        for (int c = 0; c < 100; c++) begin
          @(posedge clk);
          ce_prev = ce;
          @(negedge clk);
          if (!ce_prev) begin
            check("hold_sum",   $signed(s4s), $signed(last_sum));
            check("hold_valid", {31'd0, v4s}, {31'd0, last_v});
          end else if (v4s) begin
            if (exp_q.size() == 0) begin
              check("extra_output", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("stream_sum", $signed(s4s), $signed(e[15:0]));
              check("stream_ovf", {31'd0, ov4s}, {31'd0, e[16]});
            end
            out_cnt++;
          end
          last_sum = s4s; last_v = v4s;
        end
      end
    join
    check("stream_out_count", out_cnt, 8);
    check("stream_queue_empty", exp_q.size(), 0);

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    ce = 1'b1; valid = 1'b1; shift = 4'd0; data4 = pack4(100, 200, 300, 400);
    @(negedge clk);
    data4 = pack4(500, 600, 700, 800);
    @(negedge clk);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, v4s}, 0);
    check("async_rst_sum",   $signed(s4s), 0);
    check("async_rst_ovf",   {31'd0, ov4s}, 0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (v4s || v4w || v3) stale++;
    end
    check("no_stale_valid", stale, 0);
    beat("post_rst", 1, 2, 3, 4, 5, 6, 7, 4'd0,
         10, 0, 10, 0, 18, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
